// File: rtl/instruction_fetch_unit_pkg.sv
// Shared MIPS fetch definitions: fetch FSM states,
// NOP encoding, default reset PC and program image limit.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] ADDR_LIMIT_DEF = 32'd512;

  function automatic logic [31:0] align_word(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port: fetch drives the
// word address, memory returns data combinationally.
interface instruction_fetch_unit_if;
  logic [31:0] InstrAddress;
  logic [31:0] Instruction;

  modport master (
    output InstrAddress,
    input  Instruction
  );

  modport slave (
    input  InstrAddress,
    output Instruction
  );
endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter: async reset, load enable,
// low two bits always cleared.
module pc_register
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= align_word(RESET_PC);
    end else if (load) begin
      q <= {d[31:2], 2'b00};
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, boot/fetch/halt FSM and the
// IF/ID pipeline register.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic                            Clk,
  input  logic                            Reset,
  instruction_fetch_unit_if.master        imem,
  input  logic                            Stall,
  input  logic                            Redirect,
  input  logic [31:0]                     RedirectTarget,
  output logic [31:0]                     IF_ID_Instruction,
  output logic [31:0]                     IF_ID_PCPlus4,
  output logic                            IF_ID_Valid,
  output logic                            Halted
);

  fetch_state_e state, state_nxt;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic        pc_load;
  logic [31:0] pc_d;
  logic [31:0] instr_nxt;
  logic [31:0] p4_nxt;
  logic        valid_nxt;

  assign pc_plus4 = pc + 32'd4;
  assign tgt      = align_word(RedirectTarget);

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk  (Clk),
    .rst  (Reset),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_d      = pc;
    instr_nxt = IF_ID_Instruction;
    p4_nxt    = IF_ID_PCPlus4;
    valid_nxt = IF_ID_Valid;
    unique case (state)
      BOOT: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (Redirect) begin
          pc_load   = 1'b1;
          pc_d      = tgt;
          valid_nxt = 1'b0;
          instr_nxt = NOP_INSTR;
          if (tgt >= ADDR_LIMIT) state_nxt = HALTED;
        end else if (!Stall) begin
          instr_nxt = imem.Instruction;
          p4_nxt    = pc_plus4;
          valid_nxt = 1'b1;
          // last word: keep PC parked on it
          if (pc_plus4 >= ADDR_LIMIT) begin
            state_nxt = HALTED;
          end else begin
            pc_load = 1'b1;
            pc_d    = pc_plus4;
          end
        end
      end
      HALTED: begin
        valid_nxt = 1'b0;
        if (Redirect && (tgt < ADDR_LIMIT)) begin
          pc_load   = 1'b1;
          pc_d      = tgt;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IF_ID_Instruction <= NOP_INSTR;
      IF_ID_PCPlus4     <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end else begin
      IF_ID_Instruction <= instr_nxt;
      IF_ID_PCPlus4     <= p4_nxt;
      IF_ID_Valid       <= valid_nxt;
    end
  end

  assign imem.InstrAddress = pc;
  assign Halted            = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios
// then random stall/redirect against a reference model.
module tb_instruction_fetch_unit;
  import mips_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        Halted;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .imem              (bus),
    .Stall             (Stall),
    .Redirect          (Redirect),
    .RedirectTarget    (RedirectTarget),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .Halted            (Halted)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [128];

  assign bus.Instruction = (bus.InstrAddress < 32'd512)
                         ? mem[bus.InstrAddress[8:2]]
                         : 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  // reference model: mode 0 boot, 1 running, 2 halted
  logic [31:0] m_pc, m_ins, m_p4;
  logic        m_v;
  int          m_mode;

  function automatic logic [31:0] m_fetch(
    input logic [31:0] a
  );
    if (a < 32'd512) return mem[a / 4];
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0;
    m_ins  = 32'h0;
    m_p4   = 32'h0;
    m_v    = 1'b0;
    m_mode = 0;
  endtask

  task automatic model_edge(
    input logic        st,
    input logic        rd,
    input logic [31:0] tg
  );
    logic [31:0] t;
    t = tg - (tg % 4);
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rd) begin
        m_pc  = t;
        m_v   = 1'b0;
        m_ins = 32'h0;
        if (t >= 512) m_mode = 2;
      end else if (!st) begin
        m_ins = m_fetch(m_pc);
        m_p4  = m_pc + 4;
        m_v   = 1'b1;
        if (m_pc + 4 >= 512) m_mode = 2;
        else m_pc = m_pc + 4;
      end
    end else begin
      m_v = 1'b0;
      if (rd && t < 512) begin
        m_pc   = t;
        m_mode = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/pc"},    bus.InstrAddress,  m_pc);
    check({tag, "/ins"},   IF_ID_Instruction, m_ins);
    check({tag, "/p4"},    IF_ID_PCPlus4,     m_p4);
    check({tag, "/valid"}, {31'b0, IF_ID_Valid},
          {31'b0, m_v});
    check({tag, "/halt"},  {31'b0, Halted},
          {31'b0, (m_mode == 2)});
  endtask

  task automatic step(
    input string       tag,
    input logic        st,
    input logic        rd,
    input logic [31:0] tg
  );
    Stall          = st;
    Redirect       = rd;
    RedirectTarget = tg;
    model_edge(st, rd, tg);
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic        st, rd;
    logic [31:0] tg;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[0] = 32'h2010000e;
    mem[1] = 32'h2011000f;
    mem[2] = 32'h2012001d;

    Reset          = 1'b1;
    Stall          = 1'b0;
    Redirect       = 1'b0;
    RedirectTarget = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    Reset = 1'b0;

    step("boot", 1'b0, 1'b0, 32'h0);
    step("run1", 1'b0, 1'b0, 32'h0);
    check("run1_word0", IF_ID_Instruction, 32'h2010000e);
    step("run2", 1'b0, 1'b0, 32'h0);
    check("run2_addr8", bus.InstrAddress, 32'd8);

    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b1, 1'b0, 32'h0);
    end
    check("stall_ins", IF_ID_Instruction, 32'h2011000f);
    step("resume", 1'b0, 1'b0, 32'h0);
    check("resume_ins", IF_ID_Instruction, 32'h2012001d);

    step("redir", 1'b1, 1'b1, 32'h0000003E);
    check("redir_pc", bus.InstrAddress, 32'h3C);
    step("redir_tgt", 1'b0, 1'b0, 32'h0);
    check("redir_p4", IF_ID_PCPlus4, 32'd64);

    for (int i = 0; i < 200; i++) begin
      if (m_mode == 1 && m_pc == 32'd508) break;
      step("walk", 1'b0, 1'b0, 32'h0);
    end
    check("walk_508", bus.InstrAddress, 32'd508);
    step("last", 1'b0, 1'b0, 32'h0);
    check("last_p4", IF_ID_PCPlus4, 32'd512);
    check("last_halt", {31'b0, Halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step("parked", 1'($urandom_range(0, 1)),
           1'b0, 32'h0);
    end

    step("h_oob", 1'b0, 1'b1, 32'h200);
    check("h_oob_halt", {31'b0, Halted}, 32'd1);
    step("h_back", 1'b0, 1'b1, 32'h0);
    step("h_word0", 1'b0, 1'b0, 32'h0);
    check("h_word0_ins", IF_ID_Instruction, 32'h2010000e);

    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 9) < 8) tg = $urandom_range(0, 511);
      else tg = $urandom_range(512, 700);
      step("rand", st, rd, tg);
    end

    Redirect       = 1'b1;
    RedirectTarget = 32'h40;
    Stall          = 1'b0;
    #3;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #1;
    Reset    = 1'b0;
    Redirect = 1'b0;
    step("post_boot", 1'b0, 1'b0, 32'h0);
    step("post_run", 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction-fetch stage of the single-issue MIPS datapath: owns the program counter, drives the word address into the combinational `InstructionMemory`, and captures the returned instruction into the IF/ID pipeline register. It supports stall, redirect (branch/jump flush) and an end-of-program halt. It is the requesting side of the instruction-memory read interface.

## Interface
- `RESET_PC`, 32'h00000000: PC value loaded on reset.
- `ADDR_LIMIT`, 32'd512: first byte address past the program image (128 words × 4).
- `Clk`  in  1: rising-edge clock.
- `Reset`  in  1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `InstrAddress`  out  32: byte address to instruction memory, equal to the PC register. Bits [1:0] are always 0.
- `Instruction`  in  32: combinational read data from instruction memory for `InstrAddress`.
- `Stall`  in  1: hazard unit holds the PC and IF/ID contents.
- `Redirect`  in  1: a taken branch or jump; load `RedirectTarget` and flush IF/ID.
- `RedirectTarget`  in  32: new PC. Bits [1:0] are forced to 0 internally.
- `IF_ID_Instruction`  out  32: registered instruction.
- `IF_ID_PCPlus4`  out  32: registered PC+4 of that instruction.
- `IF_ID_Valid`  out  1: IF/ID holds a real instruction. When low, downstream treats the stage as a NOP.
- `Halted`  out  1: high while the FSM is in HALTED.

## Operation
- FSM states: BOOT, FETCH, HALTED. The encoding is 2 bits.
- Reset (async) sets:
  - PC = `RESET_PC`
  - `IF_ID_Instruction` = 0
  - `IF_ID_PCPlus4` = 0
  - `IF_ID_Valid` = 0
  - state = BOOT, so `Halted` = 0
- BOOT lasts exactly one cycle after reset deasserts. The PC holds and IF/ID stays invalid. The next state is FETCH unconditionally, and inputs are ignored.
- In FETCH, each edge is evaluated in priority order Redirect > Stall > advance:
  - Redirect:
    - PC ← {`RedirectTarget`[31:2], 2'b00}
    - `IF_ID_Valid` ← 0 and `IF_ID_Instruction` ← 0 (flush)
    - If the aligned target is ≥ `ADDR_LIMIT`, the next state is HALTED.
  - Stall (no Redirect): PC and all IF/ID outputs hold.
  - Advance:
    - IF/ID ← {`Instruction`, PC+4, valid=1}
    - If PC+4 ≥ `ADDR_LIMIT`, PC holds and the next state is HALTED. Otherwise PC ← PC+4.
- In HALTED:
  - `IF_ID_Valid` ← 0 on the first edge, then stays 0. The PC holds.
  - `Stall` is ignored.
  - `Redirect` with an aligned target < `ADDR_LIMIT` loads the PC and returns to FETCH. Redirect to a target out of range stays in HALTED.
- PC+4 uses 32-bit wrap-around arithmetic. Wrap is unreachable while `ADDR_LIMIT` ≤ 2^32−4.
- Reset mid-operation discards all state immediately, including in-flight flush and halt.

## Timing
- `InstrAddress` is a pure register output, with no combinational path from any input.
- Fetch latency: the instruction at address A appears on `IF_ID_Instruction` one edge after PC = A in FETCH with no stall or redirect.
- After reset deasserts, the first valid IF/ID appears at the end of the 2nd edge (BOOT + 1 fetch).
- Redirect penalty: one bubble (`IF_ID_Valid`=0) the cycle after the redirect edge. The target instruction is valid one edge later.
- Stall is level-sensitive, one cycle held per cycle asserted. There is no limit on stall length.
- The last word (`ADDR_LIMIT`−4) is captured valid on the same edge that enters HALTED. `Halted` rises on that edge.

## Structure
- Shared package `mips_pkg`:
  - fetch state enum (BOOT/FETCH/HALTED)
  - `NOP_INSTR` = 32'h00000000
  - default `RESET_PC` and `ADDR_LIMIT`
- One sub-module, `pc_register`: a 32-bit register with async reset to `RESET_PC`, load enable and alignment masking.
- The FSM and the IF/ID register live in the top module.

## Test plan
- Bench memory model: word0 = 32'h2010000e, word1 = 32'h2011000f, word2 = 32'h2012001d.
- Reset, then 4 free-running cycles:
  - `InstrAddress` sequence 0, 0, 4, 8, 12.
  - IF/ID becomes {32'h2010000e, 4, valid} after edge 2, then {32'h2011000f, 8, valid}.
- Stall held 3 cycles at PC=8: `InstrAddress` stays 8 and IF/ID stays {32'h2011000f, 8} for 3 edges. It resumes with 32'h2012001d.
- Redirect to 32'h0000003E with Stall also high: PC becomes 32'h3C, and the next edge gives `IF_ID_Valid`=0. The edge after that gives IF/ID {word15, 64, valid}.
- Free-run to PC=508: word127 is captured valid with PCPlus4=512, and `Halted` rises on the same edge. The next edge gives valid=0. PC stays at 508 for 10 cycles.
- In HALTED:
  - Redirect to 32'h200 stays halted.
  - Redirect to 32'h0 returns to FETCH, and word0 is valid one edge later.
- Assert Reset asynchronously between edges during a redirect: outputs are 0/invalid immediately, PC=0, state BOOT. No capture occurs on the next edge.
